// File: rtl/reg_bank_sb.sv
// Parametrised register bank with two registered read ports, same-cycle write
// bypass, optional hardwired zero register and a per-register busy scoreboard.
module reg_bank_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   opwrite,
  input  logic [ADDR_W-1:0]      reg_write,
  input  logic [DATA_W-1:0]      data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      src_1,
  input  logic [ADDR_W-1:0]      src_2,
  output logic                   rd_stall,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      data_src_1,
  output logic [DATA_W-1:0]      data_src_2,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                rd_valid_r;
  logic [DATA_W-1:0]   data_src_1_r;
  logic [DATA_W-1:0]   data_src_2_r;

  logic                wr_en_s;
  logic                hit_1_s;
  logic                hit_2_s;
  logic                conflict_1_s;
  logic                conflict_2_s;
  logic                stall_s;
  logic                accept_s;
  logic [DATA_W-1:0]   rd_data_1_s;
  logic [DATA_W-1:0]   rd_data_2_s;

  // True when the address names the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Write/bypass hits, scoreboard conflicts and the accepted read data.
  always_comb begin
    wr_en_s      = opwrite && !is_zero(reg_write);
    hit_1_s      = wr_en_s && (reg_write == src_1);
    hit_2_s      = wr_en_s && (reg_write == src_2);
    // A writeback landing this cycle releases its register immediately.
    conflict_1_s = busy_r[src_1] && !hit_1_s && !is_zero(src_1);
    conflict_2_s = busy_r[src_2] && !hit_2_s && !is_zero(src_2);
    stall_s      = rd_en && (conflict_1_s || conflict_2_s);
    accept_s     = rd_en && !stall_s;

    rd_data_1_s = regs_r[src_1];
    if (is_zero(src_1)) begin
      rd_data_1_s = {DATA_W{1'b0}};
    end else if (hit_1_s) begin
      rd_data_1_s = data;
    end else begin
      rd_data_1_s = regs_r[src_1];
    end

    rd_data_2_s = regs_r[src_2];
    if (is_zero(src_2)) begin
      rd_data_2_s = {DATA_W{1'b0}};
    end else if (hit_2_s) begin
      rd_data_2_s = data;
    end else begin
      rd_data_2_s = regs_r[src_2];
    end
  end

  // Scoreboard next state: writeback clears, then a reservation sets (set wins).
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsv_en && (rsv_addr == ADDR_W'(i)) && !is_zero(rsv_addr)) begin
        busy_next_s[i] = 1'b1;
      end else if (opwrite && (reg_write == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Register file, scoreboard and read-port state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      busy_r       <= {NUM_REGS{1'b0}};
      rd_valid_r   <= 1'b0;
      data_src_1_r <= {DATA_W{1'b0}};
      data_src_2_r <= {DATA_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        regs_r[reg_write] <= data;
      end
      busy_r     <= busy_next_s;
      rd_valid_r <= accept_s;
      if (accept_s) begin
        data_src_1_r <= rd_data_1_s;
        data_src_2_r <= rd_data_2_s;
      end
    end
  end

  assign rd_stall   = stall_s;
  assign rd_valid   = rd_valid_r;
  assign data_src_1 = data_src_1_r;
  assign data_src_2 = data_src_2_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed, table-driven bench for reg_bank_sb (DATA_W=32, ADDR_W=2, ZERO_REG=1).
module tb_reg_bank_sb;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        opwrite;
  logic [1:0]  reg_write;
  logic [31:0] data;
  logic        rsv_en;
  logic [1:0]  rsv_addr;
  logic        rd_en;
  logic [1:0]  src_1;
  logic [1:0]  src_2;
  logic        rd_stall;
  logic        rd_valid;
  logic [31:0] data_src_1;
  logic [31:0] data_src_2;
  logic [3:0]  busy;

  int checks   = 0;
  int failures = 0;

  reg_bank_sb #(.DATA_W(32), .ADDR_W(2), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .opwrite(opwrite), .reg_write(reg_write),
    .data(data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_en(rd_en),
    .src_1(src_1), .src_2(src_2), .rd_stall(rd_stall), .rd_valid(rd_valid),
    .data_src_1(data_src_1), .data_src_2(data_src_2), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic        rsv;
    logic [1:0]  ra;
    logic        rd;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic        x_stall;
    logic        x_valid;
    logic [31:0] x_d1;
    logic [31:0] x_d2;
    logic [3:0]  x_busy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic rst_n, input logic wr, input logic [1:0] wa,
                              input logic [31:0] wd, input logic rsv, input logic [1:0] ra,
                              input logic rd, input logic [1:0] s1, input logic [1:0] s2,
                              input logic x_stall, input logic x_valid, input logic [31:0] x_d1,
                              input logic [31:0] x_d2, input logic [3:0] x_busy);
    vec_t v;
    v.rst_n = rst_n; v.wr = wr; v.wa = wa; v.wd = wd; v.rsv = rsv; v.ra = ra;
    v.rd = rd; v.s1 = s1; v.s2 = s2; v.x_stall = x_stall; v.x_valid = x_valid;
    v.x_d1 = x_d1; v.x_d2 = x_d2; v.x_busy = x_busy;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic wr, input logic [1:0] wa,
                       input logic [31:0] wd, input logic rsv, input logic [1:0] ra,
                       input logic rd, input logic [1:0] s1, input logic [1:0] s2);
    RST_N = rst_n; opwrite = wr; reg_write = wa; data = wd;
    rsv_en = rsv; rsv_addr = ra; rd_en = rd; src_1 = s1; src_2 = s2;
  endtask

  initial begin
    int  stalls;
    logic accepted;

    drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);

    //               rst  wr   wa    wd            rsv  ra    rd   s1    s2    stall valid d1            d2            busy
    vecs[0]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0);
    vecs[1]  = mk(1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0);
    vecs[2]  = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0);
    vecs[3]  = mk(1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0);
    vecs[4]  = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0);
    vecs[5]  = mk(1'b1, 1'b1, 2'd2, 32'h12345678, 1'b0, 2'd0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 32'h12345678, 32'hDEADBEEF, 4'h0);
    vecs[6]  = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF, 4'h8);
    vecs[7]  = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF, 4'h8);
    vecs[8]  = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF, 4'h8);
    vecs[9]  = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF, 4'h8);
    vecs[10] = mk(1'b1, 1'b1, 2'd3, 32'hA5,       1'b0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b0, 1'b1, 32'h0,        32'hA5,       4'h0);
    vecs[11] = mk(1'b1, 1'b1, 2'd0, 32'hFFFFFFFF, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,        32'hA5,       4'h0);
    vecs[12] = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0);
    vecs[13] = mk(1'b1, 1'b1, 2'd0, 32'hFFFFFFFF, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0);
    vecs[14] = mk(1'b1, 1'b1, 2'd1, 32'h55,       1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h2);
    vecs[15] = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 32'h0,        32'h0,        4'h2);
    vecs[16] = mk(1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0);
    vecs[17] = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 32'h0,        32'h0,        4'h0);
    vecs[18] = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 2'd2, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 32'h0,        32'h0,        4'h4);
    vecs[19] = mk(1'b1, 1'b1, 2'd2, 32'h77,       1'b1, 2'd2, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 32'h77,       32'h0,        4'h4);
    vecs[20] = mk(1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 32'h77,       32'h0,        4'h4);
    vecs[21] = mk(1'b1, 1'b1, 2'd2, 32'h99,       1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1, 32'h99,       32'h99,       4'h0);

    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      drive(vecs[i].rst_n, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rsv,
            vecs[i].ra, vecs[i].rd, vecs[i].s1, vecs[i].s2);
      #1;
      check("rd_stall", i, {31'd0, rd_stall}, {31'd0, vecs[i].x_stall});
      @(posedge CLK);
      #1;
      check("rd_valid", i, {31'd0, rd_valid}, {31'd0, vecs[i].x_valid});
      check("data_src_1", i, data_src_1, vecs[i].x_d1);
      check("data_src_2", i, data_src_2, vecs[i].x_d2);
      check("busy", i, {28'd0, busy}, {28'd0, vecs[i].x_busy});
    end

    // Reserve r3, then a held read of r3 released by a writeback after two stalls.
    @(negedge CLK);
    drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 2'd3, 1'b0, 2'd0, 2'd0);
    @(posedge CLK);
    #1;
    check("seq_busy_set", 100, {28'd0, busy}, 32'h8);
    stalls   = 0;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(negedge CLK);
      drive(1'b1, (i == 2), 2'd3, 32'h0000CAFE, 1'b0, 2'd0, 1'b1, 2'd3, 2'd3);
      #1;
      if (rd_stall) stalls++;
      else accepted = 1'b1;
      @(posedge CLK);
      #1;
    end
    check("seq_accepted", 101, {31'd0, accepted}, 32'd1);
    check("seq_stall_cycles", 102, stalls, 32'd2);
    check("seq_valid", 103, {31'd0, rd_valid}, 32'd1);
    check("seq_data_src_1", 104, data_src_1, 32'h0000CAFE);
    check("seq_data_src_2", 105, data_src_2, 32'h0000CAFE);
    check("seq_busy_clear", 106, {28'd0, busy}, 32'h0);

    @(negedge CLK);
    drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    @(posedge CLK);
    #1;
    check("idle_valid", 107, {31'd0, rd_valid}, 32'd0);
    check("idle_hold", 108, data_src_1, 32'h0000CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- Parametrised successor to the fixed 4-entry register bank.
- Provides configurable data width and register count, an optional hardwired zero register, and two registered read ports with same-cycle write bypass.
- Adds a per-register busy scoreboard: the issue stage reserves a destination, and the writeback stage clears the reservation.
- Reads of a reserved register stall until its writeback.
- Sits between decode and the ALU/writeback path of the datapath.

Parameters:
- DATA_W, 32, width of each register and of the data buses.
- ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy; 0 = register 0 is an ordinary register.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- opwrite  in  1  write enable (writeback).
- reg_write  in  ADDR_W  write address.
- data  in  DATA_W  write data.
- rsv_en  in  1  reserve destination (sets busy).
- rsv_addr  in  ADDR_W  register to reserve.
- rd_en  in  1  read request for src_1/src_2.
- src_1  in  ADDR_W  read address, port 1.
- src_2  in  ADDR_W  read address, port 2.
- rd_stall  out  1  combinational: read request cannot be accepted this cycle.
- rd_valid  out  1  registered: data_src_1/2 carry a newly accepted read.
- data_src_1  out  DATA_W  registered read data, port 1.
- data_src_2  out  DATA_W  registered read data, port 2.
- busy  out  NUM_REGS  registered scoreboard, bit i = register i reserved.

Behaviour:
- Reset (RST_N=0 at rising edge):
  - All registers, busy, data_src_1, data_src_2 and rd_valid go to 0.
  - Reset overrides opwrite, rsv_en and rd_en in the same cycle.
  - Reset mid-stall drops the pending request; the requester must re-issue.
- Write: opwrite=1 stores data into reg[reg_write] at the rising edge.
  - Write to register 0 is discarded when ZERO_REG=1.
- Scoreboard update per edge, in priority order:
  - write clears busy[reg_write];
  - then rsv_en sets busy[rsv_addr].
  - Same address in both: busy ends set (new reservation wins, data still written).
  - rsv_en to register 0 with ZERO_REG=1 is ignored.
  - Reserving an already-busy register keeps it busy (no counting).
- Conflict per port: address n conflicts when busy[n]=1 and not (opwrite=1 and reg_write=n).
  - A write landing this cycle resolves the conflict.
- Stall: rd_stall = rd_en & (conflict on src_1 | conflict on src_2). rd_stall is 0 when rd_en=0.
- Read accept: rd_en=1 and rd_stall=0 at an edge.
  - data_src_1/2 load the register values; rd_valid=1 for the next cycle (latency 1).
  - Bypass: if opwrite=1 and reg_write equals the source address (non-zero when ZERO_REG=1), the output loads data, not the old register value.
- No accept: rd_valid=0 next cycle and data_src_1/2 hold their previous values.
  - The requester holds rd_en and its addresses stable while stalled.
- Same address on both ports: both outputs are identical, including bypass.
- Register 0 with ZERO_REG=1 always reads 0 and never causes a stall.
- No X propagation: outputs are defined from the first edge after reset.

Test Plan:
- Reset then read: RST_N=0 for 2 cycles, then rd_en src_1=1 src_2=2 -> rd_stall=0, next cycle rd_valid=1, data_src_1=0, data_src_2=0, busy=0.
- Write then read: write 0xDEADBEEF to r1, then rd_en src_1=1 src_2=1 the following cycle -> data_src_1=data_src_2=0xDEADBEEF, rd_valid=1 one cycle after the request.
- Bypass: same cycle opwrite reg_write=2 data=0x12345678 and rd_en src_1=2 -> rd_stall=0, next cycle data_src_1=0x12345678.
- Scoreboard stall:
  - rsv_en rsv_addr=3, then rd_en src_2=3 for 3 cycles -> rd_stall=1, rd_valid=0, outputs held, busy[3]=1.
  - Then opwrite reg_write=3 data=0xA5 -> rd_stall=0 that cycle, next cycle data_src_2=0xA5, busy[3]=0.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and rsv_en r0 -> busy[0]=0; read src_1=0 -> data_src_1=0, no stall.
- Simultaneous write+reserve on r1 with data 0x55, then reset asserted while a read of r1 is stalled -> before reset: reg1=0x55, busy[1]=1, rd_stall=1; after reset: busy=0, rd_valid=0, reg1=0.
